// File: rtl/dmem_if.sv
// Core-to-data-memory request/response bundle.
// The master drives requests and the slave returns responses.
interface dmem_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: sized loads/stores with lane steering and extension,
// alignment/range checks, optional wait states and a valid/ready stall handshake.
module dmem_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  accept;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [OFF_W-1:0]      off;
  logic [ADDR_WIDTH-1:0] idx;
  logic [IDX_W-1:0]      idx_t;
  logic [3:0]            nbytes;
  logic                  misaligned, illegal_size, out_of_range, req_err;
  logic [NB-1:0]         be;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic                  mem_we;

  logic                  we_q, uns_q, err_q;
  logic [1:0]            size_q;
  logic [OFF_W-1:0]      off_q;
  logic [DATA_WIDTH-1:0] rd_word_q;
  logic [DATA_WIDTH-1:0] rdata_hold_q;
  logic                  err_hold_q;

  logic [DATA_WIDTH-1:0] shifted, ext;
  logic                  sgn;
  int                    nbits;

  // Request decode
  assign off          = bus.req_addr[OFF_W-1:0];
  assign idx          = bus.req_addr >> OFF_W;
  assign idx_t        = idx[IDX_W-1:0];
  assign nbytes       = 4'd1 << bus.req_size;
  assign misaligned   = (off & OFF_W'(nbytes - 4'd1)) != '0;
  assign illegal_size = (bus.req_size == 2'd3) && (DATA_WIDTH < 64);
  assign out_of_range = idx >= ADDR_WIDTH'(MEM_DEPTH);
  assign req_err      = misaligned | illegal_size | out_of_range;

  always_comb begin
    be = '0;
    for (int b = 0; b < int'(NB); b++) begin
      be[b] = (b >= int'(off)) && (b < int'(off) + int'(nbytes));
    end
    wdata_sh = bus.req_wdata << {off, 3'b000};
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (req_err || (WAIT_CYCLES == 0)) begin
            state_d = StResp;
          end else begin
            cnt_d   = 3'(WAIT_CYCLES);
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      err_q        <= 1'b0;
      size_q       <= '0;
      off_q        <= '0;
      rd_word_q    <= '0;
      rdata_hold_q <= '0;
      err_hold_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q   <= bus.req_we;
        uns_q  <= bus.req_unsigned;
        err_q  <= req_err;
        size_q <= bus.req_size;
        off_q  <= off;
        if (!req_err) begin
          rd_word_q <= mem[idx_t];
        end
      end
      if (state_q == StResp) begin
        rdata_hold_q <= ext;
        err_hold_q   <= err_q;
      end
    end
  end

  // Stores commit on the accept edge; a reset in the same edge suppresses them.
  assign mem_we = accept & bus.req_we & ~req_err & ~rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (be[b]) begin
          mem[idx_t][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  // Load extraction and extension from the captured word
  always_comb begin
    shifted = rd_word_q >> {off_q, 3'b000};
    nbits   = 8 << size_q;
    case (size_q)
      2'd0:    sgn = shifted[7];
      2'd1:    sgn = shifted[15];
      2'd2:    sgn = shifted[31];
      default: sgn = shifted[DATA_WIDTH-1];
    endcase
    ext = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      ext[i] = (i < nbits) ? shifted[i] : (sgn & ~uns_q);
    end
    if (we_q || err_q) begin
      ext = '0;
    end
  end

  // Response data is live during RESP and held afterwards until the next one.
  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_rdata = (state_q == StResp) ? ext : rdata_hold_q;
  assign bus.resp_err   = (state_q == StResp) ? err_q : err_hold_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: 32-bit zero-wait, 32-bit 3-wait and 64-bit 2-wait
// instances sharing one clock, reset and request bus.
module tb_dmem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
  logic        t_we = 1'b0, t_uns = 1'b0;
  logic [1:0]  t_size = 2'd0;
  logic [31:0] t_addr = '0;
  logic [63:0] t_wd = '0;
  int          sel = 0;

  int checks = 0;
  int errors = 0;

  dmem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_a ();
  dmem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_b ();
  dmem_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus_c ();

  assign bus_a.req_valid = valid_a;   assign bus_b.req_valid = valid_b;
  assign bus_c.req_valid = valid_c;
  assign bus_a.req_we = t_we;         assign bus_b.req_we = t_we;
  assign bus_c.req_we = t_we;
  assign bus_a.req_size = t_size;     assign bus_b.req_size = t_size;
  assign bus_c.req_size = t_size;
  assign bus_a.req_unsigned = t_uns;  assign bus_b.req_unsigned = t_uns;
  assign bus_c.req_unsigned = t_uns;
  assign bus_a.req_addr = t_addr;     assign bus_b.req_addr = t_addr;
  assign bus_c.req_addr = t_addr;
  assign bus_a.req_wdata = t_wd[31:0];
  assign bus_b.req_wdata = t_wd[31:0];
  assign bus_c.req_wdata = t_wd;

  dmem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(1024), .WAIT_CYCLES(0)) u_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  dmem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(1024), .WAIT_CYCLES(3)) u_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );
  dmem_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .MEM_DEPTH(1024), .WAIT_CYCLES(2)) u_c (
    .clk(clk), .rst(rst), .bus(bus_c)
  );

  logic        s_rv, s_err, s_rdy;
  logic [63:0] s_rd;
  always_comb begin
    s_rv = bus_a.resp_valid; s_err = bus_a.resp_err; s_rdy = bus_a.req_ready;
    s_rd = {32'b0, bus_a.resp_rdata};
    if (sel == 1) begin
      s_rv = bus_b.resp_valid; s_err = bus_b.resp_err; s_rdy = bus_b.req_ready;
      s_rd = {32'b0, bus_b.resp_rdata};
    end else if (sel == 2) begin
      s_rv = bus_c.resp_valid; s_err = bus_c.resp_err; s_rdy = bus_c.req_ready;
      s_rd = bus_c.resp_rdata;
    end
  end

  logic [63:0] rd;
  logic        er;
  int          lat;

  // Issues one request to an idle DUT and reports data, error and latency (0 = no response).
  task automatic access(input int dut, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [63:0] wd,
                        output logic [63:0] o_rd, output logic o_err, output int o_lat);
    sel = dut;
    @(negedge clk);
    t_we = we; t_size = size; t_uns = uns; t_addr = addr; t_wd = wd;
    valid_a = (dut == 0); valid_b = (dut == 1); valid_c = (dut == 2);
    @(posedge clk);
    o_rd = '0; o_err = 1'b0; o_lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
      if (s_rv) begin
        o_rd = s_rd; o_err = s_err; o_lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus_a.req_ready !== 1'b1 || bus_a.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_a_hs: ready=%b valid=%b required ready=1 valid=0",
               bus_a.req_ready, bus_a.resp_valid);
    end
    checks++;
    if (bus_a.resp_rdata !== 32'h0 || bus_a.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_a_data: rdata=%h err=%b required 0/0", bus_a.resp_rdata, bus_a.resp_err);
    end
    checks++;
    if (bus_c.req_ready !== 1'b1 || bus_c.resp_valid !== 1'b0 || bus_c.resp_rdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_c: ready=%b valid=%b rdata=%h required 1/0/0",
               bus_c.req_ready, bus_c.resp_valid, bus_c.resp_rdata);
    end
  endtask

  task automatic test_store_load();
    access(0, 1'b1, 2'd2, 1'b0, 32'h10, 64'hDEADBEEF, rd, er, lat);
    checks++;
    if (lat !== 1 || er !== 1'b0 || rd !== 64'h0) begin
      errors++;
      $display("FAIL store_word: lat=%0d err=%b rdata=%h required 1/0/0", lat, er, rd);
    end
    access(0, 1'b0, 2'd0, 1'b0, 32'h13, 64'h0, rd, er, lat);
    checks++;
    if (lat !== 1 || er !== 1'b0 || rd !== 64'hFFFFFFDE) begin
      errors++;
      $display("FAIL load_byte_s: lat=%0d err=%b rdata=%h required 1/0/ffffffde", lat, er, rd);
    end
    access(0, 1'b0, 2'd0, 1'b1, 32'h10, 64'h0, rd, er, lat);
    checks++;
    if (rd !== 64'h000000EF || er !== 1'b0) begin
      errors++;
      $display("FAIL load_byte_u: rdata=%h err=%b required 000000ef/0", rd, er);
    end
  endtask

  task automatic test_half();
    access(0, 1'b1, 2'd1, 1'b0, 32'h12, 64'h1234, rd, er, lat);
    access(0, 1'b0, 2'd2, 1'b0, 32'h10, 64'h0, rd, er, lat);
    checks++;
    if (rd !== 64'h1234BEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL half_merge: rdata=%h err=%b required 1234beef/0", rd, er);
    end
    access(0, 1'b0, 2'd1, 1'b1, 32'h12, 64'h0, rd, er, lat);
    checks++;
    if (rd !== 64'h00001234) begin
      errors++;
      $display("FAIL load_half_u: rdata=%h required 00001234", rd);
    end
    access(0, 1'b0, 2'd1, 1'b0, 32'h10, 64'h0, rd, er, lat);
    checks++;
    if (rd !== 64'hFFFFBEEF) begin
      errors++;
      $display("FAIL load_half_s: rdata=%h required ffffbeef", rd);
    end
    // Held after the response pulse
    @(negedge clk);
    checks++;
    if (s_rv !== 1'b0 || s_rd !== 64'hFFFFBEEF) begin
      errors++;
      $display("FAIL hold_rdata: valid=%b rdata=%h required 0/ffffbeef", s_rv, s_rd);
    end
  endtask

  task automatic test_errors();
    access(0, 1'b0, 2'd2, 1'b0, 32'h11, 64'h0, rd, er, lat);
    checks++;
    if (lat !== 1 || er !== 1'b1 || rd !== 64'h0) begin
      errors++;
      $display("FAIL misalign_word: lat=%0d err=%b rdata=%h required 1/1/0", lat, er, rd);
    end
    @(negedge clk);
    checks++;
    if (s_err !== 1'b1 || s_rd !== 64'h0) begin
      errors++;
      $display("FAIL hold_err: err=%b rdata=%h required 1/0", s_err, s_rd);
    end
    access(0, 1'b1, 2'd1, 1'b0, 32'h13, 64'hFFFF, rd, er, lat);
    checks++;
    if (lat !== 1 || er !== 1'b1) begin
      errors++;
      $display("FAIL misalign_half: lat=%0d err=%b required 1/1", lat, er);
    end
    access(0, 1'b0, 2'd2, 1'b0, 32'h10, 64'h0, rd, er, lat);
    checks++;
    if (rd !== 64'h1234BEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL no_write_on_err: rdata=%h err=%b required 1234beef/0", rd, er);
    end
    access(0, 1'b0, 2'd2, 1'b0, 32'h1000, 64'h0, rd, er, lat);
    checks++;
    if (lat !== 1 || er !== 1'b1 || rd !== 64'h0) begin
      errors++;
      $display("FAIL out_of_range: lat=%0d err=%b rdata=%h required 1/1/0", lat, er, rd);
    end
    access(0, 1'b0, 2'd3, 1'b0, 32'h0, 64'h0, rd, er, lat);
    checks++;
    if (lat !== 1 || er !== 1'b1) begin
      errors++;
      $display("FAIL size3_on_32: lat=%0d err=%b required 1/1", lat, er);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_rdy [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic exp_rv  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    access(1, 1'b1, 2'd2, 1'b0, 32'h20, 64'hCAFEF00D, rd, er, lat);
    checks++;
    if (lat !== 4 || er !== 1'b0) begin
      errors++;
      $display("FAIL wait_store_lat: lat=%0d err=%b required 4/0", lat, er);
    end
    sel = 1;
    @(negedge clk);
    t_we = 1'b0; t_size = 2'd2; t_uns = 1'b0; t_addr = 32'h20; valid_b = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 6) valid_b = 1'b0;
      checks++;
      if (s_rdy !== exp_rdy[k-1] || s_rv !== exp_rv[k-1]) begin
        errors++;
        $display("FAIL b2b_cycle%0d: ready=%b valid=%b required %b/%b",
                 k, s_rdy, s_rv, exp_rdy[k-1], exp_rv[k-1]);
      end
      if (exp_rv[k-1]) begin
        checks++;
        if (s_rd !== 64'hCAFEF00D) begin
          errors++;
          $display("FAIL b2b_data%0d: rdata=%h required cafef00d", k, s_rd);
        end
      end
    end
  endtask

  task automatic test_double();
    access(2, 1'b1, 2'd3, 1'b0, 32'h8, 64'h0123456789ABCDEF, rd, er, lat);
    checks++;
    if (lat !== 3 || er !== 1'b0) begin
      errors++;
      $display("FAIL d64_store: lat=%0d err=%b required 3/0", lat, er);
    end
    access(2, 1'b0, 2'd2, 1'b0, 32'hC, 64'h0, rd, er, lat);
    checks++;
    if (rd !== 64'h0000000001234567 || er !== 1'b0) begin
      errors++;
      $display("FAIL d64_word_hi: rdata=%h err=%b required 0000000001234567/0", rd, er);
    end
    access(2, 1'b0, 2'd2, 1'b0, 32'h8, 64'h0, rd, er, lat);
    checks++;
    if (rd !== 64'hFFFFFFFF89ABCDEF) begin
      errors++;
      $display("FAIL d64_word_lo: rdata=%h required ffffffff89abcdef", rd);
    end
    access(2, 1'b0, 2'd0, 1'b1, 32'hF, 64'h0, rd, er, lat);
    checks++;
    if (rd !== 64'h01) begin
      errors++;
      $display("FAIL d64_byte_u: rdata=%h required 01", rd);
    end
    access(2, 1'b0, 2'd3, 1'b0, 32'hC, 64'h0, rd, er, lat);
    checks++;
    if (lat !== 1 || er !== 1'b1 || rd !== 64'h0) begin
      errors++;
      $display("FAIL d64_misalign: lat=%0d err=%b rdata=%h required 1/1/0", lat, er, rd);
    end
  endtask

  task automatic test_reset_busy();
    int seen;
    sel = 2;
    @(negedge clk);
    t_we = 1'b0; t_size = 2'd3; t_uns = 1'b0; t_addr = 32'h8; valid_c = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_c = 1'b0;
    checks++;
    if (bus_c.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready: ready=%b required 0", bus_c.req_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus_c.req_ready !== 1'b1 || bus_c.resp_valid !== 1'b0 || bus_c.resp_rdata !== 64'h0) begin
      errors++;
      $display("FAIL rst_busy: ready=%b valid=%b rdata=%h required 1/0/0",
               bus_c.req_ready, bus_c.resp_valid, bus_c.resp_rdata);
    end
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus_c.resp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL dropped_resp: resp_valid pulses=%0d required 0", seen);
    end
    access(2, 1'b0, 2'd3, 1'b0, 32'h8, 64'h0, rd, er, lat);
    checks++;
    if (lat !== 3 || rd !== 64'h0123456789ABCDEF || er !== 1'b0) begin
      errors++;
      $display("FAIL after_rst_load: lat=%0d rdata=%h err=%b required 3/0123456789abcdef/0",
               lat, rd, er);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_store_load();
    test_half();
    test_errors();
    test_back_to_back();
    test_double();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
